// File: rtl/rr_onehot_arbiter_pkg.sv
// rr_onehot_arbiter_pkg: shared FSM state encoding and index-width helper for the round-robin arbiter.
package rr_onehot_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  function automatic int clog2_fn(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_onehot_arbiter_encoder.sv
// onehot_encoder: OR-only one-hot to binary mapping; input zero-extended to 2**OUTPUT_W.
module onehot_encoder #(
  parameter int INPUT_W  = 8,
  parameter int OUTPUT_W = 3
) (
  input  logic [INPUT_W-1:0]  onehot_i,
  output logic [OUTPUT_W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < INPUT_W; i++)
      for (int b = 0; b < OUTPUT_W; b++)
        if (i[b]) idx_o[b] = idx_o[b] | onehot_i[i];
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: locked round-robin arbiter with registered one-hot grant and encoded index.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int REQ_NUM = 8,
  parameter int IDX_W   = clog2_fn(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req_i,
  input  logic               done_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  state_e             state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d, base, therm, hi, cand, pick;
  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_sel, owner_idx;
  logic               rel;

  onehot_encoder #(.INPUT_W(REQ_NUM), .OUTPUT_W(IDX_W)) u_enc (
    .onehot_i (gnt_q),
    .idx_o    (owner_idx)
  );

  assign rel     = (state_q == LOCK) && (done_i || !(|(req_i & gnt_q)));
  assign ptr_sel = rel ? ((owner_idx == IDX_W'(REQ_NUM - 1)) ? '0 : owner_idx + 1'b1) : ptr_q;
  // On release the owner is masked so it cannot immediately win again.
  assign base    = rel ? (req_i & ~gnt_q) : req_i;

  always_comb begin
    therm = '0;
    for (int i = 0; i < REQ_NUM; i++) therm[i] = (IDX_W'(i) >= ptr_sel);
  end

  // Lowest set bit at/above ptr, else lowest set bit overall (wrap).
  assign hi   = base & therm;
  assign cand = (|hi) ? hi : base;
  assign pick = cand & (~cand + REQ_NUM'(1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    if (state_q == IDLE || rel) begin
      ptr_d   = ptr_sel;
      gnt_d   = pick;
      state_d = (|pick) ? LOCK : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = owner_idx;
  assign gnt_vld_o = |gnt_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// tb_rr_onehot_arbiter: directed vectors with hand-computed grants for 8- and 5-requester arbiters.
module tb_rr_onehot_arbiter;

  logic       clk, rst_n, done, done2;
  logic [7:0] req, gnt;
  logic [2:0] idx, idx2;
  logic       vld, vld2;
  logic [4:0] req2, gnt2;
  int         n_chk, n_fail;

  rr_onehot_arbiter #(.REQ_NUM(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .done_i    (done),
    .gnt_o     (gnt),
    .gnt_idx_o (idx),
    .gnt_vld_o (vld)
  );

  rr_onehot_arbiter #(.REQ_NUM(5), .IDX_W(3)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req2),
    .done_i    (done2),
    .gnt_o     (gnt2),
    .gnt_idx_o (idx2),
    .gnt_vld_o (vld2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [7:0] g, input logic [2:0] i);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".idx"}, 32'(idx), 32'(i));
    chk({tag, ".vld"}, 32'(vld), 32'(|g));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_pulse;
    #2 rst_n = 1'b0;
    #1;
    chk_gnt("rst_async", 8'h00, 3'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; req = '0; done = 1'b0; req2 = '0; done2 = 1'b0;
    tick;
    chk_gnt("reset", 8'h00, 3'd0);
    chk("reset5.gnt", 32'(gnt2), 32'h0);
    rst_n = 1'b1;
    // single request, then release to IDLE leaves ptr=5
    req = 8'h10; tick;
    chk_gnt("single", 8'h10, 3'd4);
    req = 8'h00; done = 1'b1; tick; done = 1'b0;
    chk_gnt("single_rel", 8'h00, 3'd0);
    req = 8'h21; tick;
    chk_gnt("ptr5", 8'h20, 3'd5);
    req = 8'h00; done = 1'b1; tick; done = 1'b0;
    chk_gnt("idle_ptr6", 8'h00, 3'd0);
    // wrap and skip from ptr=6
    req = 8'h05; tick;
    chk_gnt("wrap", 8'h01, 3'd0);
    done = 1'b1; tick; done = 1'b0;
    chk_gnt("skip", 8'h04, 3'd2);
    req = 8'h00; done = 1'b1; tick; done = 1'b0;
    chk_gnt("idle_ptr3", 8'h00, 3'd0);
    // abandon
    req = 8'h0A; tick;
    chk_gnt("abandon_own", 8'h08, 3'd3);
    req = 8'h02; tick;
    chk_gnt("abandon", 8'h02, 3'd1);
    req = 8'h00; done = 1'b1; tick;
    chk_gnt("idle_ptr2", 8'h00, 3'd0);
    tick; done = 1'b0;
    chk_gnt("idle_done", 8'h00, 3'd0);
    req = 8'h12; tick;
    chk_gnt("ptr_kept", 8'h10, 3'd4);
    req = 8'h13; tick;
    chk_gnt("lock_hold", 8'h10, 3'd4);
    req = 8'h00; done = 1'b1; tick; done = 1'b0;
    chk_gnt("idle_ptr5", 8'h00, 3'd0);
    // reset mid-lock
    req = 8'h20; tick;
    chk_gnt("pre_rst", 8'h20, 3'd5);
    rst_pulse;
    req = 8'h01; tick;
    chk_gnt("post_rst", 8'h01, 3'd0);
    // fairness from ptr=0
    rst_pulse;
    req = 8'hFF; tick;
    chk_gnt("fair0", 8'h01, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("fair_hold1", 32'(idx), 32'(k - 1));
      tick;
      chk("fair_hold2", 32'(idx), 32'(k - 1));
      done = 1'b1; tick; done = 1'b0;
      chk_gnt("fair", 8'(1 << (k % 8)), 3'(k % 8));
    end
    // simultaneous done and owner drop counts once
    req = 8'hFE; done = 1'b1; tick; done = 1'b0;
    chk_gnt("simul", 8'h02, 3'd1);
    req = 8'h00; done = 1'b1; tick; done = 1'b0;
    chk_gnt("final_idle", 8'h00, 3'd0);
    // non-power-of-two
    req2 = 5'h1F; tick;
    chk("np2.idx", 32'(idx2), 32'd0);
    chk("np2.gnt", 32'(gnt2), 32'h01);
    done2 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick;
      chk("np2.idx", 32'(idx2), 32'(k % 5));
      chk("np2.gnt", 32'(gnt2), 32'(1 << (k % 5)));
      chk("np2.vld", 32'(vld2), 32'd1);
    end
    done2 = 1'b0; req2 = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among REQ_NUM requesters.
- Produces a registered one-hot grant vector plus its binary index.
- The index comes from an onehot_encoder instance, so the encoder's OR-only mapping is the single source of index truth.
- Sits in front of any shared datapath (bus port, encoder lane, memory port) that needs a locked, fair, one-owner-at-a-time grant.

Parameters:
- REQ_NUM, 8, number of requesters; 2..2**IDX_W.
- IDX_W, 3, grant index width; must satisfy 2**IDX_W >= REQ_NUM.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_i  input  REQ_NUM  per-requester request level; held high until served.
- done_i  input  1  one-cycle pulse from the resource: the current owner's transfer has finished.
- gnt_o  output  REQ_NUM  registered one-hot grant; all-zero when idle.
- gnt_idx_o  output  IDX_W  binary index of gnt_o; 0 when idle.
- gnt_vld_o  output  1  high while any grant is held (equals |gnt_o).

Behaviour:
- Reset (rst_n low, any time, including mid-grant):
  - gnt_o=0, gnt_idx_o=0, gnt_vld_o=0.
  - Priority pointer ptr=0; state=IDLE.
  - Takes effect immediately, with no clock required.
- States: IDLE, LOCK.
- IDLE:
  - If req_i != 0: select the first set bit of req_i at or above ptr, wrapping to bit 0.
  - Register it into gnt_o; go to LOCK.
  - Latency: req_i high at edge N gives gnt_o valid after edge N+1 (1 cycle).
  - If req_i == 0: stay in IDLE with outputs 0.
- LOCK:
  - gnt_o is held constant, and req_i changes of other requesters are ignored, until a release event.
  - Release events: done_i==1, or the owner's req_i bit sampled 0 (abandon).
  - On release, ptr := (owner index + 1) mod REQ_NUM.
  - Arbitration restarts in the same cycle using the updated ptr and req_i with the owner bit masked off.
  - If another requester is pending, the new grant is registered at the next edge with no idle bubble; stay in LOCK.
  - If nothing else is pending, go to IDLE with outputs 0.
  - The owner re-requesting immediately does not win while others are pending. It wins only when it is the sole requester, and then only after at least 1 cycle in IDLE.
- Simultaneous done_i and owner-drop count as a single release.
- done_i in IDLE is ignored; ptr is unchanged.
- Wrap-around:
  - Search order is ptr, ptr+1, …, REQ_NUM-1, 0, …, ptr-1.
  - ptr never takes a value >= REQ_NUM.
- Non-power-of-two REQ_NUM: the grant vector is zero-extended to 2**IDX_W before the encoder, and unused indices are never produced.
- Invariants:
  - gnt_o has at most one bit set.
  - gnt_vld_o == |gnt_o.
  - gnt_idx_o == encode(gnt_o).
  - gnt_o only changes on a clock edge or on reset.
- Arithmetic: the selection mask uses a double-width (2*REQ_NUM) rotate, or a thermometer mask from ptr. No priority encoder on the index path; the index is derived solely from the registered one-hot vector.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, LOCK=1'b1) and the IDX_W rule as a clog2 helper constant function.
- One sub-module: onehot_encoder (INPUT_W=REQ_NUM, OUTPUT_W=IDX_W), driven by gnt_o, producing gnt_idx_o combinationally from the register.
- Everything else (mask, rotate, pointer, FSM) lives in rr_onehot_arbiter.

Test Plan:
- Reset mid-LOCK: grant held on requester 5, rst_n pulsed low between edges → gnt_o=0, gnt_idx_o=0 immediately; after release, req_i=8'h01 → gnt_o=8'h01 one cycle later.
- Single request: req_i=8'h10 from IDLE → next cycle gnt_o=8'h10, gnt_idx_o=4, gnt_vld_o=1; done_i pulse with req_i=0 → IDLE, outputs 0, ptr=5.
- Fairness: req_i=8'hFF held, done_i every 3rd cycle → gnt_idx_o sequence 0,1,2,…,7,0 with no idle gaps between grants.
- Wrap and skip: ptr=6, req_i=8'h05 → grant index 0, then on done_i index 2 (ptr=1 skips to 2).
- Abandon: owner 3 drops req_i while req_i[1] is high → next edge gnt_o=8'h02; done_i in IDLE leaves ptr unchanged.
- Non-power-of-two: REQ_NUM=5, IDX_W=3, req_i=5'h1F → indices cycle 0..4 only, gnt_idx_o never 5–7.
